// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle add/sub, CHUNK bits per clock with registered chunk carry
// Optional Overflow/Zero flag outputs are built only when ADDER_FLAGS_EN is defined.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef ADDER_FLAGS_EN
  ,
  output logic             Overflow,
  output logic             Zero
`endif
);

  localparam int STEPS  = WIDTH / CHUNK;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               carry_out_q, carry_out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic               last_step;
`ifdef ADDER_FLAGS_EN
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
`endif

  assign last_step = (step_q == STEP_W'(STEPS - 1));

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef ADDER_FLAGS_EN
    overflow_d  = overflow_q;
    zero_d      = zero_q;
`endif
    // Constant-index mux keeps every slice select static.
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (step_q == STEP_W'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = A;
          b_d        = sub ? ~B : B;
          carry_d    = CarryIn;
          step_d     = '0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
        end
      end
      BUSY: begin
        for (int k = 0; k < STEPS; k++) begin
          if (step_q == STEP_W'(k)) sum_d[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        end
        carry_d = chunk_sum[CHUNK];
        if (last_step) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          carry_out_d = chunk_sum[CHUNK];
`ifdef ADDER_FLAGS_EN
          // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
          overflow_d  = chunk_sum[CHUNK] ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_sum[CHUNK-1]);
          zero_d      = (sum_d == '0);
`endif
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ADDER_FLAGS_EN
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ADDER_FLAGS_EN
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Carry     = carry_out_q;
`ifdef ADDER_FLAGS_EN
  assign Overflow  = overflow_q;
  assign Zero      = zero_q;
`endif

endmodule
